// File: rtl/gb_job_arbiter.sv
// gb_job_arbiter: shares one Gaussian_Blur accelerator between NREQ requesters.
// Whole 3x3-window jobs are granted round-robin; an in-order tag FIFO records
// the owner of each job so results can be steered back to the right requester.
module gb_job_arbiter #(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned WORDS_PER_JOB = 9,
  parameter int unsigned TAG_DEPTH     = 4,
  parameter int unsigned DATA_W        = 25,
  parameter int unsigned RES_W         = 32
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NREQ-1:0]                i_req_vld,
  input  logic [NREQ*DATA_W-1:0]         i_req_data,
  output logic [NREQ-1:0]                o_req_busy,
  output logic                           o_acc_rgb_vld,
  output logic [DATA_W-1:0]              o_acc_rgb_data,
  input  logic                           i_acc_rgb_busy,
  input  logic                           i_acc_result_vld,
  input  logic [RES_W-1:0]               i_acc_result_data,
  output logic                           o_acc_result_busy,
  output logic [NREQ-1:0]                o_rsp_vld,
  output logic [RES_W-1:0]               o_rsp_data,
  input  logic [NREQ-1:0]                i_rsp_busy,
  output logic [$clog2(TAG_DEPTH+1)-1:0] o_inflight,
  output logic                           o_err_orphan
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (WORDS_PER_JOB > 1) ? $clog2(WORDS_PER_JOB) : 1;
  localparam int unsigned PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned OW = $clog2(TAG_DEPTH + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [GW-1:0] mem_q [TAG_DEPTH];

  logic [GW-1:0] pick;
  logic          pick_vld;
  logic          full, empty;
  logic [GW-1:0] head;
  logic          acc_xfer, last_word, push, pop;

  assign full      = (count_q == OW'(TAG_DEPTH));
  assign empty     = (count_q == '0);
  assign head      = mem_q[rd_ptr_q];
  assign acc_xfer  = o_acc_rgb_vld & ~i_acc_rgb_busy;
  assign last_word = (word_cnt_q == CW'(WORDS_PER_JOB - 1));
  assign push      = acc_xfer & last_word;
  assign pop       = i_acc_result_vld & ~o_acc_result_busy;

  assign o_inflight   = count_q;
  assign o_err_orphan = err_q;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_ptr_q) + i) % NREQ;
      if (!pick_vld && i_req_vld[GW'(idx)]) begin
        pick_vld = 1'b1;
        pick     = GW'(idx);
      end
    end
  end

  // Request-side steering: only the granted requester sees the accelerator.
  always_comb begin
    o_req_busy     = '1;
    o_acc_rgb_vld  = 1'b0;
    o_acc_rgb_data = '0;
    if (state_q == ST_STREAM) begin
      o_acc_rgb_vld       = i_req_vld[grant_q];
      o_req_busy[grant_q] = i_acc_rgb_busy;
      for (int k = 0; k < int'(NREQ); k++) begin
        if (grant_q == GW'(k)) o_acc_rgb_data = i_req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Result-side steering to the owner of the oldest outstanding job.
  always_comb begin
    o_rsp_vld         = '0;
    o_rsp_data        = '0;
    o_acc_result_busy = 1'b1;
    if (!empty) begin
      o_rsp_vld[head]   = i_acc_result_vld;
      o_rsp_data        = i_acc_result_data;
      o_acc_result_busy = i_rsp_busy[head];
    end
  end

  // Next-state logic for the job FSM, tag FIFO pointers and orphan flag.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    word_cnt_d = word_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_d      = err_q | (empty & i_acc_result_vld);

    case (state_q)
      ST_IDLE: begin
        if (pick_vld && !full) begin
          grant_d    = pick;
          word_cnt_d = '0;
          state_d    = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (acc_xfer) begin
          if (last_word) begin
            word_cnt_d = '0;
            rr_ptr_d   = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
            state_d    = ST_IDLE;
          end else begin
            word_cnt_d = word_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + OW'(1);
      2'b01:   count_d = count_q - OW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      word_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      word_cnt_q <= word_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  // Tag storage; contents are only meaningful between the pointers.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= grant_q;
  end

endmodule

// File: tb/tb_gb_job_arbiter.sv
// Directed bench for gb_job_arbiter: a vector table for a single job plus
// cycle-driven sequences for round-robin, FIFO full, back-pressure and reset.
module tb_gb_job_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned WPJ  = 9;
  localparam int unsigned TD   = 4;
  localparam int unsigned DW   = 25;
  localparam int unsigned RW   = 32;
  localparam int unsigned OW   = $clog2(TD + 1);

  logic                 clk;
  logic                 i_rst;
  logic [NREQ-1:0]      i_req_vld;
  logic [NREQ*DW-1:0]   i_req_data;
  logic [NREQ-1:0]      o_req_busy;
  logic                 o_acc_rgb_vld;
  logic [DW-1:0]        o_acc_rgb_data;
  logic                 i_acc_rgb_busy;
  logic                 i_acc_result_vld;
  logic [RW-1:0]        i_acc_result_data;
  logic                 o_acc_result_busy;
  logic [NREQ-1:0]      o_rsp_vld;
  logic [RW-1:0]        o_rsp_data;
  logic [NREQ-1:0]      i_rsp_busy;
  logic [OW-1:0]        o_inflight;
  logic                 o_err_orphan;

  gb_job_arbiter #(
    .NREQ(NREQ), .WORDS_PER_JOB(WPJ), .TAG_DEPTH(TD), .DATA_W(DW), .RES_W(RW)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_vld(i_req_vld), .i_req_data(i_req_data), .o_req_busy(o_req_busy),
    .o_acc_rgb_vld(o_acc_rgb_vld), .o_acc_rgb_data(o_acc_rgb_data),
    .i_acc_rgb_busy(i_acc_rgb_busy),
    .i_acc_result_vld(i_acc_result_vld), .i_acc_result_data(i_acc_result_data),
    .o_acc_result_busy(o_acc_result_busy),
    .o_rsp_vld(o_rsp_vld), .o_rsp_data(o_rsp_data), .i_rsp_busy(i_rsp_busy),
    .o_inflight(o_inflight), .o_err_orphan(o_err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Vector table for the single-job sequence (requester 2).
  typedef struct {
    logic [NREQ-1:0] vld;
    logic [DW-1:0]   word;
    logic            res_vld;
    logic [RW-1:0]   res_data;
    logic            e_vld;
    logic [DW-1:0]   e_data;
    logic [NREQ-1:0] e_busy;
    logic [NREQ-1:0] e_rsp_vld;
    logic [RW-1:0]   e_rsp_data;
    logic            e_res_busy;
    int              e_infl;
  } vec_t;

  function automatic vec_t mv(logic [NREQ-1:0] vld, logic [DW-1:0] word, logic res_vld,
                              logic [RW-1:0] res_data, logic e_vld, logic [DW-1:0] e_data,
                              logic [NREQ-1:0] e_busy, logic [NREQ-1:0] e_rsp_vld,
                              logic [RW-1:0] e_rsp_data, logic e_res_busy, int e_infl);
    vec_t v;
    v.vld = vld; v.word = word; v.res_vld = res_vld; v.res_data = res_data;
    v.e_vld = e_vld; v.e_data = e_data; v.e_busy = e_busy; v.e_rsp_vld = e_rsp_vld;
    v.e_rsp_data = e_rsp_data; v.e_res_busy = e_res_busy; v.e_infl = e_infl;
    return v;
  endfunction

  // Requester / accelerator model state for the cycle-driven sequences.
  int          jobs_left [NREQ];
  int          jobw      [NREQ];
  int          wtot      [NREQ];
  int          q[$];
  int          grant_log[$];
  int          grant_cyc[$];
  int          res_log[$];
  int          cyc;
  int          res_seq;
  logic        acc_busy_v;
  logic [NREQ-1:0] rsp_busy_v;
  logic        res_en;
  logic        pop_on_last;

  task automatic clear_model();
    for (int k = 0; k < int'(NREQ); k++) begin
      jobs_left[k] = 0; jobw[k] = 0; wtot[k] = 0;
    end
    q.delete(); grant_log.delete(); grant_cyc.delete(); res_log.delete();
    cyc = 0; res_seq = 0; acc_busy_v = 1'b0; rsp_busy_v = '0; res_en = 1'b0;
    pop_on_last = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst = 1'b1;
    i_req_vld = '0; i_req_data = '0; i_acc_rgb_busy = 1'b0;
    i_acc_result_vld = 1'b0; i_acc_result_data = '0; i_rsp_busy = '0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    clear_model();
  endtask

  // One clock of the requester/accelerator model with per-cycle checks.
  task automatic tick();
    logic [NREQ-1:0]    v;
    logic [NREQ*DW-1:0] d;
    logic               rd;
    int                 ng, g, h;
    @(negedge clk);
    cyc++;
    v = '0; d = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      v[k] = (jobs_left[k] > 0);
      d[k*DW +: DW] = DW'((k << 12) | wtot[k]);
    end
    rd = (q.size() > 0) && (res_en || (pop_on_last && jobw[0] == int'(WPJ) - 1));
    i_req_vld = v; i_req_data = d; i_acc_rgb_busy = acc_busy_v;
    i_acc_result_vld = rd; i_acc_result_data = 32'hC0DE_0000 + RW'(res_seq);
    i_rsp_busy = rsp_busy_v;
    #1;
    ng = 0; g = 0;
    for (int k = 0; k < int'(NREQ); k++) if (!o_req_busy[k]) begin ng++; g = k; end
    chk("grant_onehot", 64'(ng <= 1), 64'd1);
    if (ng == 1) begin
      chk("acc_vld", o_acc_rgb_vld, v[g]);
      if (v[g]) chk("acc_data", o_acc_rgb_data, d[g*DW +: DW]);
    end else if (!acc_busy_v) begin
      chk("idle_vld", o_acc_rgb_vld, 1'b0);
      chk("idle_data", o_acc_rgb_data, '0);
    end
    chk("inflight", o_inflight, q.size());
    if (q.size() > 0) begin
      h = q[0];
      chk("rsp_vld", o_rsp_vld, NREQ'(rd) << h);
      if (rd) chk("rsp_data", o_rsp_data, 32'hC0DE_0000 + RW'(res_seq));
      chk("res_busy", o_acc_result_busy, rsp_busy_v[h]);
      if (rd && !rsp_busy_v[h]) begin
        void'(q.pop_front());
        res_log.push_back(h);
        res_seq++;
      end
    end else begin
      chk("rsp_vld_empty", o_rsp_vld, '0);
      chk("res_busy_empty", o_acc_result_busy, 1'b1);
    end
    if (ng == 1 && v[g]) begin
      if (jobw[g] == 0) begin
        grant_log.push_back(g);
        grant_cyc.push_back(cyc);
      end
      wtot[g]++;
      jobw[g]++;
      if (jobw[g] == int'(WPJ)) begin
        jobw[g] = 0;
        jobs_left[g]--;
        q.push_back(g);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[12];
    int   exp_order[5];
    int   n;

    i_rst = 1'b1;
    clear_model();
    do_reset();

    // Reset values.
    #1;
    chk("rst_req_busy", o_req_busy, 4'b1111);
    chk("rst_acc_vld", o_acc_rgb_vld, 1'b0);
    chk("rst_acc_data", o_acc_rgb_data, '0);
    chk("rst_rsp_vld", o_rsp_vld, '0);
    chk("rst_rsp_data", o_rsp_data, '0);
    chk("rst_res_busy", o_acc_result_busy, 1'b1);
    chk("rst_inflight", o_inflight, '0);
    chk("rst_orphan", o_err_orphan, 1'b0);

    // Single job from requester 2, words 1..9, result 0xDEADBEEF.
    vt[0] = mv(4'b0100, 25'd1, 1'b0, '0, 1'b0, '0, 4'b1111, 4'b0000, '0, 1'b1, 0);
    for (int i = 1; i <= 9; i++)
      vt[i] = mv(4'b0100, DW'(i), 1'b0, '0, 1'b1, DW'(i), 4'b1011, 4'b0000, '0, 1'b1, 0);
    vt[10] = mv(4'b0000, '0, 1'b1, 32'hDEAD_BEEF, 1'b0, '0, 4'b1111, 4'b0100,
                32'hDEAD_BEEF, 1'b0, 1);
    vt[11] = mv(4'b0000, '0, 1'b0, '0, 1'b0, '0, 4'b1111, 4'b0000, '0, 1'b1, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      i_req_vld = vt[i].vld;
      i_req_data = '0;
      i_req_data[2*DW +: DW] = vt[i].word;
      i_acc_rgb_busy = 1'b0;
      i_acc_result_vld = vt[i].res_vld;
      i_acc_result_data = vt[i].res_data;
      i_rsp_busy = '0;
      #1;
      chk($sformatf("v%0d_acc_vld", i), o_acc_rgb_vld, vt[i].e_vld);
      chk($sformatf("v%0d_acc_data", i), o_acc_rgb_data, vt[i].e_data);
      chk($sformatf("v%0d_req_busy", i), o_req_busy, vt[i].e_busy);
      chk($sformatf("v%0d_rsp_vld", i), o_rsp_vld, vt[i].e_rsp_vld);
      chk($sformatf("v%0d_rsp_data", i), o_rsp_data, vt[i].e_rsp_data);
      chk($sformatf("v%0d_res_busy", i), o_acc_result_busy, vt[i].e_res_busy);
      chk($sformatf("v%0d_inflight", i), o_inflight, vt[i].e_infl);
    end

    // Round-robin with all requesters pending, then tag FIFO full.
    do_reset();
    jobs_left[0] = 2; jobs_left[1] = 1; jobs_left[2] = 1; jobs_left[3] = 1;
    n = 0;
    while (n < 100 && !(grant_log.size() == 4 && q.size() == 4)) begin tick(); n++; end
    chk("rr_four_jobs_done", 64'(q.size()), 64'd4);
    for (int i = 1; i < grant_cyc.size() && i < 4; i++)
      chk($sformatf("rr_gap%0d", i), 64'(grant_cyc[i] - grant_cyc[i-1]), 64'(WPJ + 1));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_req_busy", o_req_busy, 4'b1111);
      chk("full_inflight", o_inflight, 3'd4);
    end
    res_en = 1'b1;
    tick();
    res_en = 1'b0;
    tick();
    chk("after_pop_idle", o_req_busy, 4'b1111);
    chk("after_pop_inflight", o_inflight, 3'd3);
    tick();
    chk("fifth_grant", o_req_busy, 4'b1110);

    // Last word of the 5th job coincides with requester 1's result.
    pop_on_last = 1'b1;
    n = 0;
    while (n < 30 && jobs_left[0] > 0) begin tick(); n++; end
    chk("fifth_job_done", 64'(jobs_left[0]), 64'd0);
    pop_on_last = 1'b0;
    tick();
    chk("pushpop_inflight", o_inflight, 3'd3);
    chk("pushpop_owner", 64'(res_log.size() >= 2 ? res_log[1] : -1), 64'd1);

    res_en = 1'b1;
    n = 0;
    while (n < 20 && q.size() > 0) begin tick(); n++; end
    res_en = 1'b0;
    chk("drain_done", 64'(q.size()), 64'd0);
    exp_order = '{0, 1, 2, 3, 0};
    chk("grant_count", 64'(grant_log.size()), 64'd5);
    chk("result_count", 64'(res_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      chk($sformatf("grant_order%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
    for (int i = 0; i < 5 && i < res_log.size(); i++)
      chk($sformatf("result_order%0d", i), 64'(res_log[i]), 64'(exp_order[i]));

    // Back-pressure on the accelerator input mid-job, then on the response.
    do_reset();
    jobs_left[1] = 1;
    n = 0;
    while (n < 20 && jobw[1] < 4) begin tick(); n++; end
    chk("bp_pre_busy", o_req_busy, 4'b1101);
    acc_busy_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_req_busy", o_req_busy, 4'b1111);
      chk("bp_acc_vld", o_acc_rgb_vld, 1'b1);
    end
    acc_busy_v = 1'b0;
    tick();
    chk("bp_release", o_req_busy, 4'b1101);
    n = 0;
    while (n < 20 && jobs_left[1] > 0) begin tick(); n++; end
    chk("bp_job_done", 64'(jobs_left[1]), 64'd0);
    rsp_busy_v = 4'b0010;
    res_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rspbp_res_busy", o_acc_result_busy, 1'b1);
      chk("rspbp_rsp_vld", o_rsp_vld, 4'b0010);
    end
    rsp_busy_v = '0;
    tick();
    chk("rspbp_release", o_acc_result_busy, 1'b0);
    res_en = 1'b0;
    tick();
    chk("rspbp_inflight", o_inflight, 3'd0);

    // Orphan result with FIFO empty, then reset in the middle of a job.
    do_reset();
    @(negedge clk);
    i_acc_result_vld = 1'b1;
    i_acc_result_data = 32'h1234_5678;
    #1;
    chk("orphan_res_busy", o_acc_result_busy, 1'b1);
    chk("orphan_rsp_vld", o_rsp_vld, '0);
    chk("orphan_pre", o_err_orphan, 1'b0);
    @(negedge clk);
    i_acc_result_vld = 1'b0;
    #1;
    chk("orphan_set", o_err_orphan, 1'b1);
    jobs_left[3] = 1;
    n = 0;
    while (n < 20 && jobw[3] < 5) begin tick(); n++; end
    chk("orphan_sticky", o_err_orphan, 1'b1);
    chk("midjob_busy", o_req_busy, 4'b0111);
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    chk("mrst_req_busy", o_req_busy, 4'b1111);
    chk("mrst_acc_vld", o_acc_rgb_vld, 1'b0);
    chk("mrst_acc_data", o_acc_rgb_data, '0);
    chk("mrst_rsp_vld", o_rsp_vld, '0);
    chk("mrst_rsp_data", o_rsp_data, '0);
    chk("mrst_res_busy", o_acc_result_busy, 1'b1);
    chk("mrst_inflight", o_inflight, '0);
    chk("mrst_orphan", o_err_orphan, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
